// File: rtl/mem_pkg.sv
// Shared types and encodings for the mem_bank memory block.
package mem_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/mem_lane_merge.sv
// Per-lane word merge: lanes with be set take new_word, the rest keep old_word.
module mem_lane_merge #(
  parameter int LANE_W = 5,
  parameter int LANES  = 2
) (
  input  logic [LANES*LANE_W-1:0] old_word,
  input  logic [LANES*LANE_W-1:0] new_word,
  input  logic [LANES-1:0]        be,
  output logic [LANES*LANE_W-1:0] merged
);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign merged[k*LANE_W +: LANE_W] = be[k] ? new_word[k*LANE_W +: LANE_W]
                                              : old_word[k*LANE_W +: LANE_W];
  end

endmodule

// File: rtl/mem_bank.sv
// Lane-enabled memory bank with a zeroing sweep after reset/clear,
// registered read port and out-of-range error reporting.
module mem_bank
  import mem_pkg::*;
#(
  parameter int MEM_SIZE = 6,
  parameter int LANE_W   = 5,
  parameter int LANES    = 2,
  parameter int RDW_MODE = 0,
  localparam int DATA_W  = LANES*LANE_W,
  localparam int ADDR_W  = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr_w,
  input  logic [LANES-1:0]  be,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read,
  input  logic [ADDR_W-1:0] addr_r,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              err
);

  // One extra bit so the bound still compares correctly for power-of-two sizes.
  localparam logic [ADDR_W:0]   SIZE_L = (ADDR_W+1)'(MEM_SIZE);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(MEM_SIZE-1);

  logic [DATA_W-1:0] mem [MEM_SIZE];

  state_t            state;
  logic [ADDR_W-1:0] ptr;

  logic              active, wr_in, rd_in, wr_ok, wr_bad, rd_ok, rd_bad, same;
  logic [ADDR_W-1:0] wr_idx, rd_idx;
  logic [DATA_W-1:0] wr_word, thru_word, rd_word;

  assign active = !rst && !clear && (state == READY);
  assign wr_in  = {1'b0, addr_w} < SIZE_L;
  assign rd_in  = {1'b0, addr_r} < SIZE_L;
  assign wr_idx = wr_in ? addr_w : '0;
  assign rd_idx = rd_in ? addr_r : '0;
  assign wr_ok  = active && write && wr_in;
  assign wr_bad = active && write && !wr_in;
  assign rd_ok  = active && read && rd_in;
  assign rd_bad = active && read && !rd_in;
  assign same   = wr_ok && rd_ok && (addr_w == addr_r);

  mem_lane_merge #(.LANE_W(LANE_W), .LANES(LANES)) u_wr_merge (
    .old_word (mem[wr_idx]),
    .new_word (data_in),
    .be       (be),
    .merged   (wr_word)
  );

  // Read-side merge only sees enables when the write hits the same word.
  mem_lane_merge #(.LANE_W(LANE_W), .LANES(LANES)) u_rd_merge (
    .old_word (mem[rd_idx]),
    .new_word (data_in),
    .be       (same ? be : '0),
    .merged   (thru_word)
  );

  assign rd_word = (RDW_MODE == RDW_NEW) ? thru_word : mem[rd_idx];

  // No reset on the array so it can map onto RAM; the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (!rst && !clear && state == INIT)
      mem[ptr] <= '0;
    else if (wr_ok)
      mem[wr_idx] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      ptr      <= '0;
      busy     <= 1'b1;
      data_out <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= rd_ok || rd_bad;
      err      <= wr_bad || rd_bad;
      if (rd_ok)
        data_out <= rd_word;
      else if (rd_bad)
        data_out <= '0;

      if (clear) begin
        state <= INIT;
        ptr   <= '0;
        busy  <= 1'b1;
      end else if (state == INIT) begin
        if (ptr == LAST) begin
          state <= READY;
          busy  <= 1'b0;
          ptr   <= '0;
        end else begin
          ptr <= ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bank.sv
// Directed bench for mem_bank; two instances cover both read-during-write modes.
module tb_mem_bank;

  localparam int DW = 10;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst, clear, write, read;
  logic [AW-1:0] addr_w, addr_r;
  logic [1:0]    be;
  logic [DW-1:0] data_in;

  logic [DW-1:0] d0_out, d1_out;
  logic          d0_vld, d1_vld, d0_busy, d1_busy, d0_err, d1_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_bank #(.MEM_SIZE(6), .LANE_W(5), .LANES(2), .RDW_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .clear(clear), .write(write), .addr_w(addr_w),
    .be(be), .data_in(data_in), .read(read), .addr_r(addr_r),
    .data_out(d0_out), .rd_valid(d0_vld), .busy(d0_busy), .err(d0_err)
  );

  mem_bank #(.MEM_SIZE(6), .LANE_W(5), .LANES(2), .RDW_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .write(write), .addr_w(addr_w),
    .be(be), .data_in(data_in), .read(read), .addr_r(addr_r),
    .data_out(d1_out), .rd_valid(d1_vld), .busy(d1_busy), .err(d1_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    rst = 0; clear = 0; write = 0; read = 0;
    addr_w = '0; addr_r = '0; be = '0; data_in = '0;
  endtask

  task automatic test_reset;
    int n;
    idle();
    rst = 1;
    tick();
    rst = 0;
    n_cmp++;
    if (d0_busy !== 1'b1 || d0_vld !== 1'b0 || d0_err !== 1'b0 || d0_out !== '0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b vld=%b err=%b out=%h, want 1 0 0 000", d0_busy, d0_vld, d0_err, d0_out);
    end
    n = 0;
    while (d0_busy === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    n_cmp++;
    if (n != 6) begin
      n_bad++;
      $display("FAIL reset_busy_len: got %0d cycles, want 6", n);
    end
    for (int a = 0; a < 6; a++) begin
      read = 1; addr_r = AW'(a);
      tick();
      read = 0;
      n_cmp++;
      if (d0_vld !== 1'b1 || d0_out !== '0 || d1_vld !== 1'b1 || d1_out !== '0) begin
        n_bad++;
        $display("FAIL reset_read[%0d]: vld=%b/%b out=%h/%h, want 1 000", a, d0_vld, d1_vld, d0_out, d1_out);
      end
      tick();
      n_cmp++;
      if (d0_vld !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_read_pulse[%0d]: vld=%b, want 0", a, d0_vld);
      end
    end
  endtask

  task automatic test_lanes;
    write = 1; addr_w = 2; be = 2'b11; data_in = 10'h2AB;
    tick();
    be = 2'b01; data_in = 10'h01F;
    tick();
    be = 2'b00; data_in = 10'h000;
    tick();
    write = 0; read = 1; addr_r = 2;
    tick();
    read = 0;
    n_cmp++;
    if (d0_out !== 10'h2BF || d1_out !== 10'h2BF || d0_vld !== 1'b1) begin
      n_bad++;
      $display("FAIL lane_merge: out=%h/%h vld=%b, want 2bf", d0_out, d1_out, d0_vld);
    end
    tick();
    n_cmp++;
    if (d0_out !== 10'h2BF || d0_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL data_hold: out=%h vld=%b, want 2bf 0", d0_out, d0_vld);
    end
  endtask

  task automatic test_out_of_range;
    write = 1; addr_w = 6; be = 2'b11; data_in = 10'h3FF;
    read = 1; addr_r = 7;
    tick();
    idle();
    n_cmp++;
    if (d0_err !== 1'b1 || d0_vld !== 1'b1 || d0_out !== '0 || d1_err !== 1'b1) begin
      n_bad++;
      $display("FAIL oor_both: err=%b vld=%b out=%h, want 1 1 000", d0_err, d0_vld, d0_out);
    end
    tick();
    n_cmp++;
    if (d0_err !== 1'b0 || d0_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL oor_pulse: err=%b vld=%b, want 0 0", d0_err, d0_vld);
    end
    write = 1; addr_w = 7; be = 2'b11; data_in = 10'h155;
    tick();
    idle();
    n_cmp++;
    if (d0_err !== 1'b1 || d0_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL oor_write: err=%b vld=%b, want 1 0", d0_err, d0_vld);
    end
    for (int a = 0; a < 3; a++) begin
      read = 1; addr_r = AW'(a);
      tick();
      read = 0;
      n_cmp++;
      if (d0_out !== ((a == 2) ? 10'h2BF : 10'h000) || d0_err !== 1'b0) begin
        n_bad++;
        $display("FAIL oor_nochange[%0d]: out=%h err=%b", a, d0_out, d0_err);
      end
    end
  endtask

  task automatic test_rdw;
    write = 1; addr_w = 4; be = 2'b10; data_in = 10'h3FF;
    read = 1; addr_r = 4;
    tick();
    idle();
    n_cmp++;
    if (d0_out !== 10'h000 || d1_out !== 10'h3E0) begin
      n_bad++;
      $display("FAIL rdw: out old=%h new=%h, want 000 3e0", d0_out, d1_out);
    end
    read = 1; addr_r = 4;
    tick();
    read = 0;
    n_cmp++;
    if (d0_out !== 10'h3E0 || d1_out !== 10'h3E0) begin
      n_bad++;
      $display("FAIL rdw_after: out=%h/%h, want 3e0", d0_out, d1_out);
    end
  endtask

  task automatic test_clear;
    int n;
    clear = 1;
    tick();
    clear = 0;
    tick(); tick(); tick();
    clear = 1;
    tick();
    clear = 0;
    write = 1; addr_w = 3; be = 2'b11; data_in = 10'h3FF;
    read = 1; addr_r = 7;
    n = 0;
    while (d0_busy === 1'b1 && n < 20) begin
      n++;
      tick();
      n_cmp++;
      if (d0_vld !== 1'b0 || d0_err !== 1'b0) begin
        n_bad++;
        $display("FAIL clear_ignore[%0d]: vld=%b err=%b, want 0 0", n, d0_vld, d0_err);
      end
    end
    idle();
    n_cmp++;
    if (n != 6) begin
      n_bad++;
      $display("FAIL clear_busy_len: got %0d cycles, want 6", n);
    end
    read = 1; addr_r = 3;
    tick();
    addr_r = 4;
    n_cmp++;
    if (d0_out !== '0 || d0_vld !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_addr3: out=%h vld=%b, want 000 1", d0_out, d0_vld);
    end
    tick();
    read = 0;
    n_cmp++;
    if (d1_out !== '0) begin
      n_bad++;
      $display("FAIL clear_addr4: out=%h, want 000", d1_out);
    end
  endtask

  task automatic test_reset_pending;
    int n;
    write = 1; addr_w = 1; be = 2'b11; data_in = 10'h155;
    tick();
    write = 0; read = 1; addr_r = 1;
    tick();
    n_cmp++;
    if (d0_out !== 10'h155) begin
      n_bad++;
      $display("FAIL pend_pre: out=%h, want 155", d0_out);
    end
    rst = 1;
    tick();
    idle();
    n_cmp++;
    if (d0_vld !== 1'b0 || d0_out !== '0 || d0_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL pend_reset: vld=%b out=%h busy=%b, want 0 000 1", d0_vld, d0_out, d0_busy);
    end
    n = 0;
    while (d0_busy === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    read = 1; addr_r = 1;
    tick();
    read = 0;
    n_cmp++;
    if (n != 6 || d0_out !== '0) begin
      n_bad++;
      $display("FAIL pend_sweep: busy %0d cycles out=%h, want 6 000", n, d0_out);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_lanes();
    test_out_of_range();
    test_rdw();
    test_clear();
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bank.md
MEM_BANK -- requirements
Module: mem_bank

Interface
REQ-001 The block SHALL have parameter MEM_SIZE, default 6, giving the number of words.
REQ-002 The block SHALL have parameter LANE_W, default 5, giving bits per write-enable lane.
REQ-003 The block SHALL have parameter LANES, default 2, giving lanes per word; DATA_W = LANES*LANE_W.
REQ-004 The block SHALL have parameter RDW_MODE, default 0, where 0 = read-old-data and 1 = write-through on same-address read/write.
REQ-005 The block SHALL derive ADDR_W = max(1, $clog2(MEM_SIZE)) locally.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port clear, input, 1 bit: a one-cycle request to re-run the zero sweep.
REQ-009 The block SHALL have port write, input, 1 bit: write request.
REQ-010 The block SHALL have port addr_w, input, ADDR_W bits: write address.
REQ-011 The block SHALL have port be, input, LANES bits: per-lane write enable; bit k covers data_in[k*LANE_W +: LANE_W].
REQ-012 The block SHALL have port data_in, input, DATA_W bits: write data.
REQ-013 The block SHALL have port read, input, 1 bit: read request.
REQ-014 The block SHALL have port addr_r, input, ADDR_W bits: read address.
REQ-015 The block SHALL have port data_out, output, DATA_W bits: registered read data.
REQ-016 The block SHALL have port rd_valid, output, 1 bit: one-cycle pulse marking data_out as new.
REQ-017 The block SHALL have port busy, output, 1 bit: high while the zero sweep runs.
REQ-018 The block SHALL have port err, output, 1 bit: one-cycle pulse on an out-of-range access.

Function
REQ-019 The FSM SHALL have states INIT and READY; rst or clear SHALL force INIT with sweep pointer 0.
REQ-020 In INIT the block SHALL write zero to word[ptr] each cycle, increment ptr, and enter READY on the cycle after writing MEM_SIZE-1; the sweep therefore lasts exactly MEM_SIZE cycles.
REQ-021 busy SHALL equal (state == INIT), as a registered output.
REQ-022 In INIT, write and read SHALL be ignored: no memory update, no rd_valid, no err.
REQ-023 In READY, write with addr_w < MEM_SIZE SHALL update only the lanes with be[k]=1; be=0 leaves memory unchanged.
REQ-024 In READY, read with addr_r < MEM_SIZE SHALL load data_out and pulse rd_valid on the following cycle (latency 1).
REQ-025 data_out SHALL hold its value when no read is accepted.
REQ-026 A same-cycle write and read to the same in-range address SHALL return: old word if RDW_MODE=0; per lane, data_in where be[k]=1 and old data elsewhere if RDW_MODE=1.
REQ-027 Write with addr_w >= MEM_SIZE SHALL be dropped and SHALL pulse err on the next cycle.
REQ-028 Read with addr_r >= MEM_SIZE SHALL set data_out to 0, pulse rd_valid and pulse err on the next cycle.
REQ-029 err SHALL be a single pulse when a bad write and a bad read occur in the same cycle.
REQ-030 clear during INIT SHALL restart the sweep at ptr 0; clear in READY SHALL drop that cycle's read and write.

Reset
REQ-031 On rst, data_out, rd_valid and err SHALL be 0, busy SHALL be 1 from the next cycle, state SHALL be INIT, and ptr SHALL be 0.
REQ-032 Memory contents SHALL be zeroed only by the sweep, not in one cycle, so the array can map to RAM; reset mid-sweep SHALL restart the sweep.

Structure
REQ-033 Package mem_pkg SHALL hold the state enum type (INIT, READY) and the RDW_MODE encodings RDW_OLD=0 and RDW_NEW=1.
REQ-034 The lane-merge logic (old word, new word, be -> merged word) SHALL be the sub-module mem_lane_merge, used for both the write path and the write-through path.

Verification
REQ-035 Apply rst for 1 cycle: busy=1 for exactly 6 cycles, then 0; reading addresses 0..5 returns 0 with rd_valid one cycle after each read.
REQ-036 After init, write addr 2 with be=2'b11 and data 10'h2AB, then addr 2 with be=2'b01 and data 10'h01F: read addr 2 returns 10'h2BF.
REQ-037 Write addr_w=6 and read addr_r=7 in the same cycle: one err pulse, data_out=0, rd_valid=1, no memory change.
REQ-038 Same-address write and read at addr 4 (old word 0, data_in 10'h3FF, be=2'b10): RDW_MODE=0 returns 10'h000; RDW_MODE=1 returns 10'h3E0.
REQ-039 Assert clear at sweep cycle 3: busy stays high for 6 more cycles; write and read issued meanwhile produce no rd_valid and no memory change.
REQ-040 Assert rst for 1 cycle while a read is pending: next cycle rd_valid=0, data_out=0, busy=1.
